// File: rtl/scaler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scaler_pkg : shared constants for the rate_generator divider slice   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package scaler_pkg;

  localparam int unsigned DEFAULT_RESET_DIV = 150000;
  localparam int unsigned MAX_CHANNELS      = 16;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage : scaler_pkg
`default_nettype wire

// File: rtl/rate_generator_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rate_generator_if : enable/sync/config inputs and tick outputs       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface rate_generator_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32
);

  logic [CHANNELS-1:0] enable;
  logic                sync;
  logic                cfg_we;
  logic [3:0]          cfg_ch;
  logic [WIDTH-1:0]    cfg_div;
  logic                cfg_oneshot;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] clock_hz;
  logic [CHANNELS-1:0] active;

  modport master (
    output enable, sync, cfg_we, cfg_ch, cfg_div, cfg_oneshot,
    input  tick, clock_hz, active
  );

  modport slave (
    input  enable, sync, cfg_we, cfg_ch, cfg_div, cfg_oneshot,
    output tick, clock_hz, active
  );

endinterface : rate_generator_if
`default_nettype wire

// File: rtl/scaler_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scaler_channel : one programmable divider, periodic or one-shot      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module scaler_channel
  import scaler_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_RESET_DIV)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_enable,
  input  wire logic             i_restart,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_load_div,
  input  wire logic             i_load_oneshot,
  output logic                  o_tick,
  output logic                  o_clock_hz,
  output logic                  o_active
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div;
  logic             r_oneshot;
  logic             r_halted;
  logic             r_tick;
  logic             r_clock_hz;

  logic             w_expire;

  assign w_expire = (r_cnt == r_div);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_div      <= RESET_DIV;
      r_oneshot  <= MODE_PERIODIC;
      r_halted   <= 1'b0;
      r_tick     <= 1'b0;
      r_clock_hz <= 1'b0;
    end else if (i_load || i_restart) begin
      // Restart wins over a coincident expiry, so no tick this cycle.
      if (i_load) begin
        r_div     <= i_load_div;
        r_oneshot <= i_load_oneshot;
      end
      r_cnt      <= '0;
      r_halted   <= 1'b0;
      r_tick     <= 1'b0;
      r_clock_hz <= 1'b0;
    end else if (i_enable && !r_halted) begin
      if (w_expire) begin
        r_cnt      <= '0;
        r_tick     <= 1'b1;
        r_clock_hz <= ~r_clock_hz;
        if (r_oneshot == MODE_ONESHOT) begin
          r_halted <= 1'b1;
        end
      end else begin
        r_cnt  <= r_cnt + WIDTH'(1);
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign o_tick     = r_tick;
  assign o_clock_hz = r_clock_hz;
  assign o_active   = ~r_halted;

endmodule : scaler_channel
`default_nettype wire

// File: rtl/rate_generator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rate_generator : bank of independent scaler_channel dividers         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rate_generator
  import scaler_pkg::*;
#(
  parameter int               CHANNELS  = 4,
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_RESET_DIV)
) (
  input  wire logic       clock_50mhz,
  input  wire logic       reset,
  rate_generator_if.slave bus
);

  logic [CHANNELS-1:0] w_load;
  logic [CHANNELS-1:0] w_tick;
  logic [CHANNELS-1:0] w_clock_hz;
  logic [CHANNELS-1:0] w_active;

  // Indices at or above CHANNELS match no channel and are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign w_load[i] = bus.cfg_we && (bus.cfg_ch == 4'(i));

    scaler_channel #(
      .WIDTH     (WIDTH),
      .RESET_DIV (RESET_DIV)
    ) u_ch (
      .clk            (clock_50mhz),
      .rst            (reset),
      .i_enable       (bus.enable[i]),
      .i_restart      (bus.sync),
      .i_load         (w_load[i]),
      .i_load_div     (bus.cfg_div),
      .i_load_oneshot (bus.cfg_oneshot),
      .o_tick         (w_tick[i]),
      .o_clock_hz     (w_clock_hz[i]),
      .o_active       (w_active[i])
    );
  end

  assign bus.tick     = w_tick;
  assign bus.clock_hz = w_clock_hz;
  assign bus.active   = w_active;

endmodule : rate_generator
`default_nettype wire

// File: tb/tb_rate_generator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rate_generator : directed scoreboard bench for rate_generator     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_rate_generator;

  localparam int CH  = 4;
  localparam int W   = 16;
  localparam int RDV = 5;
  localparam int BUDGET = 64;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  sb_item_t sb[$];

  rate_generator_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  rate_generator #(
    .CHANNELS  (CH),
    .WIDTH     (W),
    .RESET_DIV (W'(RDV))
  ) dut (
    .clock_50mhz (clk),
    .reset       (rst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input logic [31:0] e);
    sb_item_t it;
    it.tag = tag;
    it.exp = e;
    sb.push_back(it);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    sb_item_t it;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0h expected=<entry>", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.exp) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic cfg_write(input int ch, input int div, input logic os);
    bus.cfg_we      = 1'b1;
    bus.cfg_ch      = 4'(ch);
    bus.cfg_div     = W'(div);
    bus.cfg_oneshot = os;
    step();
    bus.cfg_we      = 1'b0;
  endtask

  task automatic wait_tick(input int ch, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.tick[ch] && n < BUDGET);
  endtask

  initial begin
    int  n;
    int  cnt;
    logic ok;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.enable      = '0;
    bus.sync        = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.cfg_ch      = '0;
    bus.cfg_div     = '0;
    bus.cfg_oneshot = 1'b0;
    repeat (3) step();

    sb_push("reset_tick", 32'h0);     sb_check(32'(bus.tick));
    sb_push("reset_hz", 32'h0);       sb_check(32'(bus.clock_hz));
    sb_push("reset_active", 32'hF);   sb_check(32'(bus.active));

    // Untouched channel counts the reset terminal count.
    rst = 1'b0;
    bus.enable = '1;
    sb_push("reset_div_period", 32'(RDV + 1));
    wait_tick(3, n); sb_check(32'(n));

    // ch0 div=3 periodic
    cfg_write(0, 3, 1'b0);
    sb_push("ch0_first_tick", 32'd4);  wait_tick(0, n); sb_check(32'(n));
    sb_push("ch0_hz_after_1", 32'd1);  sb_check(32'(bus.clock_hz[0]));
    sb_push("ch0_second_tick", 32'd4); wait_tick(0, n); sb_check(32'(n));
    sb_push("ch0_hz_after_2", 32'd0);  sb_check(32'(bus.clock_hz[0]));
    sb_push("ch0_active", 32'd1);      sb_check(32'(bus.active[0]));

    // ch1 div=0: tick every cycle, clock_hz toggles every cycle
    cfg_write(1, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      sb_push("ch1_tick_hz", {30'd0, 1'b1, (k % 2 == 0) ? 1'b1 : 1'b0});
      sb_check({30'd0, bus.tick[1], bus.clock_hz[1]});
    end

    // ch2 div=5 one-shot, then re-arm
    cfg_write(2, 5, 1'b1);
    sb_push("ch2_oneshot_delay", 32'd6); wait_tick(2, n); sb_check(32'(n));
    sb_push("ch2_halted", 32'd0);        sb_check(32'(bus.active[2]));
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.tick[2]) cnt++;
    end
    sb_push("ch2_no_more_ticks", 32'd0); sb_check(32'(cnt));
    cfg_write(2, 5, 1'b1);
    sb_push("ch2_rearm_active", 32'd1);  sb_check(32'(bus.active[2]));
    sb_push("ch2_rearm_delay", 32'd6);   wait_tick(2, n); sb_check(32'(n));

    // ch0 div=9 with enable dropped 7 cycles at cnt=4
    cfg_write(0, 9, 1'b0);
    sb_push("ch0_div9_first", 32'd10); wait_tick(0, n); sb_check(32'(n));
    repeat (4) step();
    bus.enable[0] = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      if (bus.clock_hz[0] !== 1'b1 || bus.tick[0] !== 1'b0) ok = 1'b0;
    end
    sb_push("ch0_frozen_hold", 32'd1);  sb_check(32'(ok));
    bus.enable[0] = 1'b1;
    sb_push("ch0_resume_delay", 32'd6); wait_tick(0, n); sb_check(32'(n));
    sb_push("ch0_hz_after_resume", 32'd0); sb_check(32'(bus.clock_hz[0]));

    // Sync aligns channels at different phases
    cfg_write(0, 3, 1'b0);
    step();
    cfg_write(2, 3, 1'b0);
    repeat (2) step();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    sb_push("sync_hz", 32'h0);     sb_check(32'(bus.clock_hz));
    sb_push("sync_tick", 32'h0);   sb_check(32'(bus.tick));
    sb_push("sync_active", 32'hF); sb_check(32'(bus.active));
    sb_push("sync_ch0_delay", 32'd4); wait_tick(0, n); sb_check(32'(n));
    sb_push("sync_aligned", 32'h7); sb_check(32'(bus.tick));

    // Sync coincident with ch0/ch2 expiry suppresses the tick
    repeat (3) step();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    sb_push("sync_on_expiry_tick", 32'h0); sb_check(32'(bus.tick));

    // Out-of-range channel write is ignored
    cfg_write(15, 1, 1'b1);
    sb_push("bad_ch_tick", 32'h2);   sb_check(32'(bus.tick));
    sb_push("bad_ch_active", 32'hF); sb_check(32'(bus.active));
    sb_push("bad_ch_ch0_delay", 32'd3); wait_tick(0, n); sb_check(32'(n));
    sb_push("bad_ch_ch2_aligned", 32'd1); sb_check(32'(bus.tick[2]));

    // Reset mid-count
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_push("midreset_tick", 32'h0);   sb_check(32'(bus.tick));
    sb_push("midreset_hz", 32'h0);     sb_check(32'(bus.clock_hz));
    sb_push("midreset_active", 32'hF); sb_check(32'(bus.active));
    sb_push("midreset_div", 32'(RDV + 1)); wait_tick(0, n); sb_check(32'(n));
    sb_push("midreset_all_tick", 32'hF); sb_check(32'(bus.tick));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rate_generator
`default_nettype wire
